// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker: FSM state encoding,
// 2-input reference truth tables (bit i = expected y for stim == i) and a clog2 helper.
package gate_check_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam logic [3:0] TtNor  = 4'b0001;
  localparam logic [3:0] TtNand = 4'b0111;
  localparam logic [3:0] TtAnd  = 4'b1000;
  localparam logic [3:0] TtOr   = 4'b1110;
  localparam logic [3:0] TtXor  = 4'b0110;

  // Minimum of 1 so a zero-width vector is never produced.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-window counter: cleared while disabled, counts while enabled, and flags the
// last cycle of a SETTLE_CYC-long window.
module settle_timer
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = clog2(SETTLE_CYC + 1);
  localparam logic [W-1:0] LastCnt = W'(SETTLE_CYC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = en && (cnt_q == LastCnt);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive stimulus sweep and truth-table check for a combinational gate under test.
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatch, holding the failing stim.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [(1 << N_IN)-1:0] EXP_TT = 4'b0001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   pass_cnt,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            fail_seen,
  output logic            all_pass
);

  localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};

  state_e state_q;
  logic   start_q;
  logic   timer_tc;
  logic   mismatch;
  logic   stop_now;

  settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != StSettle),
    .en   (state_q == StSettle),
    .tc   (timer_tc)
  );

  assign mismatch = (dut_y != EXP_TT[stim]);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // stim doubles as the vector index so it only moves on SAMPLE -> SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      start_q        <= 1'b0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
      all_pass       <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        StIdle, StDone: begin
          if (start_q) begin
            state_q        <= StSettle;
            stim           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
            all_pass       <= 1'b0;
          end
        end
        StSettle: begin
          if (timer_tc) state_q <= StSample;
        end
        StSample: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + 1'b1;
            if (!fail_seen) begin
              first_fail_idx <= stim;
              fail_seen      <= 1'b1;
            end
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
          if (stim == LastIdx || stop_now) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= !mismatch && (fail_cnt == '0);
          end else begin
            state_q <= StSettle;
            stim    <= stim + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
